// File: rtl/aib_rx_align.sv
// AIB RX word/bit aligner: finds MARKER at one of 20 bit offsets, locks, emits aligned words.
// Optional saturating post-lock error counter when AIB_RX_ALIGN_ERRCNT_EN is defined.
module aib_rx_align #(
  parameter logic [19:0] MARKER   = 20'hABC01,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_align_en,
  input  logic        i_realign,
  input  logic [19:0] i_data0,
  input  logic [19:0] i_data1,
  output logic [19:0] o_data0,
  output logic [19:0] o_data1,
  output logic        o_valid,
  output logic        o_locked,
`ifdef AIB_RX_ALIGN_ERRCNT_EN
  output logic [15:0] o_err_cnt,
`endif
  output logic [4:0]  o_offset
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  k_q, k_d;
  logic [39:0] w_q;
  logic [39:0] dout_q, dout_d;
  logic        valid_q, valid_d;

  logic [79:0] win;
  logic [19:0] hit;
  logic        any_hit;
  logic        hit_k;
  logic [4:0]  first_k;
  logic [6:0]  kx;
  logic [3:0]  cnt_inc;

  assign win = {i_data1, i_data0, w_q};

  for (genvar g = 0; g < 20; g++) begin : g_hit
    assign hit[g] = (win[g+19:g] == MARKER);
  end

  assign any_hit = |hit;
  assign hit_k   = hit[k_q];
  assign kx      = {2'b00, k_q};
  assign cnt_inc = cnt_q + 4'd1;

  // lowest matching offset wins
  always_comb begin
    first_k = 5'd0;
    for (int i = 19; i >= 0; i--) begin
      if (hit[i]) first_k = 5'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    if (!i_align_en) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (i_realign && state_q != IDLE) begin
      state_d = SEARCH;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SEARCH;
          cnt_d   = 4'd0;
        end
        SEARCH: begin
          if (any_hit) begin
            k_d     = first_k;
            cnt_d   = 4'd1;
            state_d = (LOCK_N > 4'd1) ? VERIFY : LOCKED;
          end
        end
        VERIFY: begin
          if (hit_k) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LOCK_N) state_d = LOCKED;
          end else begin
            state_d = SEARCH;
            cnt_d   = 4'd0;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // output follows the current state, not the next one
  always_comb begin
    dout_d  = '0;
    valid_d = 1'b0;
    if (state_q == LOCKED) begin
      dout_d  = win[kx +: 40];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      k_q     <= 5'd0;
      w_q     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      w_q     <= {i_data1, i_data0};
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

`ifdef AIB_RX_ALIGN_ERRCNT_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_d != LOCKED) begin
      err_d = 16'd0;
    end else if (state_q == LOCKED && !hit_k && err_q != 16'hFFFF) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) err_q <= 16'd0;
    else          err_q <= err_d;
  end

  assign o_err_cnt = err_q;
`endif

  assign o_data0  = dout_q[19:0];
  assign o_data1  = dout_q[39:20];
  assign o_valid  = valid_q;
  assign o_locked = (state_q == LOCKED);
  assign o_offset = k_q;

endmodule

// File: tb/tb_aib_rx_align.sv
// Directed table-driven bench for aib_rx_align.
// Error-counter sequence runs only when AIB_RX_ALIGN_ERRCNT_EN is defined.
module tb_aib_rx_align;

  localparam logic [19:0] M   = 20'hABC01;
  localparam logic [19:0] R7  = 20'hE00D5;
  localparam logic [19:0] R13 = 20'h03578;
  localparam logic [19:0] P0  = 20'h1A2D5;
  localparam logic [19:0] P1  = 20'hE0089;
  localparam logic [19:0] PL  = 20'h12345;
  localparam logic [19:0] Z   = 20'h00000;

  logic        clk = 1'b0;
  logic        rst_n, en, rl;
  logic [19:0] d0, d1;
  logic [19:0] o_data0, o_data1;
  logic        o_valid, o_locked;
  logic [4:0]  o_offset;
`ifdef AIB_RX_ALIGN_ERRCNT_EN
  logic [15:0] o_err_cnt;
`endif

  always #5 clk = ~clk;

  aib_rx_align dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_align_en (en),
    .i_realign  (rl),
    .i_data0    (d0),
    .i_data1    (d1),
    .o_data0    (o_data0),
    .o_data1    (o_data1),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
`ifdef AIB_RX_ALIGN_ERRCNT_EN
    .o_err_cnt  (o_err_cnt),
`endif
    .o_offset   (o_offset)
  );

  typedef struct {
    logic        rst_n, en, rl;
    logic [19:0] d0, d1;
    logic        v, lk;
    logic [4:0]  off;
    logic [19:0] o0, o1;
  } vec_t;

  vec_t tv[$];
  int npass = 0;
  int ntot  = 0;

  task automatic add(input logic r, input logic e, input logic x,
                     input logic [19:0] a, input logic [19:0] b,
                     input logic v, input logic lk, input logic [4:0] off,
                     input logic [19:0] o0, input logic [19:0] o1);
    vec_t t;
    t.rst_n = r; t.en = e; t.rl = x; t.d0 = a; t.d1 = b;
    t.v = v; t.lk = lk; t.off = off; t.o0 = o0; t.o1 = o1;
    tv.push_back(t);
  endtask

  task automatic step(input logic r, input logic e, input logic x,
                      input logic [19:0] a, input logic [19:0] b);
    @(negedge clk);
    rst_n = r; en = e; rl = x; d0 = a; d1 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rl = 1'b0; d0 = '0; d1 = '0;

    // reset, realign while searching, lock at offset 0, sticky lock
    add(0,0,0, Z, Z,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,1, M, M,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,1,0,  Z, Z);
    add(1,1,0, M, M,   1,1,0,  M, M);
    add(1,1,0, Z, Z,   1,1,0,  M, M);
    add(1,1,0, M, M,   1,1,0,  Z, Z);
    add(0,1,0, M, M,   0,0,0,  Z, Z);
    // offset 7 with payload, then drop enable
    add(1,1,0, R7, R7, 0,0,0,  Z, Z);
    add(1,1,0, R7, R7, 0,0,7,  Z, Z);
    add(1,1,0, R7, R7, 0,0,7,  Z, Z);
    add(1,1,0, R7, R7, 0,0,7,  Z, Z);
    add(1,1,0, R7, R7, 0,1,7,  Z, Z);
    add(1,1,0, P0, P1, 1,1,7,  M, M);
    add(1,1,0, R7, R7, 1,1,7,  PL, M);
    add(1,0,0, R7, R7, 1,0,7,  M, M);
    add(1,0,0, R7, R7, 0,0,7,  Z, Z);
    // third check fails during verify, relock needs four clean hits
    add(1,1,0, M, M,   0,0,7,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,0, Z, Z,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,0,0,  Z, Z);
    add(1,1,0, M, M,   0,1,0,  Z, Z);
    add(1,1,0, M, M,   1,1,0,  M, M);
    // realign while locked, relock at offset 13
    add(1,1,1, R13,R13,1,0,0,  M, M);
    add(1,1,0, R13,R13,0,0,13, Z, Z);
    add(1,1,0, R13,R13,0,0,13, Z, Z);
    add(1,1,0, R13,R13,0,0,13, Z, Z);
    add(1,1,0, R13,R13,0,1,13, Z, Z);
    add(1,1,0, R13,R13,1,1,13, M, M);
    add(1,0,0, R13,R13,1,0,13, M, M);
    add(1,0,0, R13,R13,0,0,13, Z, Z);

    foreach (tv[i]) begin
      step(tv[i].rst_n, tv[i].en, tv[i].rl, tv[i].d0, tv[i].d1);
      ntot++;
      if (o_valid === tv[i].v && o_locked === tv[i].lk &&
          o_offset === tv[i].off && o_data0 === tv[i].o0 &&
          o_data1 === tv[i].o1)
        npass++;
      else
        $display("FAIL vec%0d got v=%b lk=%b off=%0d d0=%h d1=%h want v=%b lk=%b off=%0d d0=%h d1=%h",
                 i, o_valid, o_locked, o_offset, o_data0, o_data1,
                 tv[i].v, tv[i].lk, tv[i].off, tv[i].o0, tv[i].o1);
    end

`ifdef AIB_RX_ALIGN_ERRCNT_EN
    for (int i = 0; i < 5; i++) step(1, 1, 0, M, M);
    ntot++;
    if (o_locked === 1'b1 && o_err_cnt === 16'd0) npass++;
    else $display("FAIL err_lock got lk=%b err=%h want lk=1 err=0000", o_locked, o_err_cnt);
    for (int i = 0; i < 6; i++) step(1, 1, 0, Z, Z);
    ntot++;
    if (o_err_cnt === 16'd5) npass++;
    else $display("FAIL err_five got %h want 0005", o_err_cnt);
    for (int i = 0; i < 70000; i++) step(1, 1, 0, Z, Z);
    ntot++;
    if (o_err_cnt === 16'hFFFF) npass++;
    else $display("FAIL err_sat got %h want ffff", o_err_cnt);
    step(1, 0, 0, Z, Z);
    ntot++;
    if (o_err_cnt === 16'd0 && o_locked === 1'b0) npass++;
    else $display("FAIL err_idle got err=%h lk=%b want err=0000 lk=0", o_err_cnt, o_locked);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
